// File: rtl/alu_issue_stage_pkg.sv
// alu_issue_stage_pkg: shared widths, opcode codes and decoded-field struct
package alu_issue_stage_pkg;
  localparam int RF_AW = 5;
  localparam int DW = 32;
  localparam logic [5:0] OP_ADDU  = 6'h01;
  localparam logic [5:0] OP_ADDUI = 6'h02;
  localparam logic [5:0] OP_AND   = 6'h03;
  localparam logic [5:0] OP_OR    = 6'h04;
  localparam logic [5:0] OP_NOT   = 6'h05;
  localparam logic [5:0] OP_XOR   = 6'h06;
  localparam logic [5:0] OP_SL    = 6'h07;
  localparam logic [5:0] OP_SR    = 6'h08;
  localparam logic [5:0] OP_SRA   = 6'h09;
  typedef struct packed {
    logic [5:0]       opcode;
    logic [RF_AW-1:0] rd;
    logic [RF_AW-1:0] rs;
    logic [RF_AW-1:0] rt;
    logic [15:0]      imm;
    logic             uses_rt;
    logic             legal;
  } dec_t;
endpackage

// File: rtl/instr_field_decode.sv
// instr_field_decode: combinational split of an instruction word into fields
module instr_field_decode
  import alu_issue_stage_pkg::*;
(
  input  logic [31:0] instr,
  output dec_t        dec
);
  assign dec.opcode  = instr[31:26];
  assign dec.rd      = instr[25:21];
  assign dec.rs      = instr[20:16];
  assign dec.rt      = instr[15:11];
  assign dec.imm     = instr[15:0];
  assign dec.uses_rt = !(instr[31:26] inside {OP_ADDUI, OP_NOT});
  assign dec.legal   = instr[31:26] inside {OP_ADDU, OP_ADDUI, OP_AND, OP_OR, OP_NOT,
                                            OP_XOR, OP_SL, OP_SR, OP_SRA};
endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: ID/EX/WB front end for an external combinational alu with forwarding
module alu_issue_stage
  import alu_issue_stage_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             instr_valid,
  input  logic [31:0]      instr,
  output logic             instr_ready,
  input  logic             stall_i,
  output logic [RF_AW-1:0] rf_raddr_a,
  output logic [RF_AW-1:0] rf_raddr_b,
  input  logic [DW-1:0]    rf_rdata_a,
  input  logic [DW-1:0]    rf_rdata_b,
  output logic [5:0]       alu_opcode,
  output logic [DW-1:0]    alu_in_a,
  output logic [DW-1:0]    alu_in_b,
  input  logic [DW-1:0]    alu_out,
  input  logic [2:0]       alu_flags,
  output logic             wb_en,
  output logic [RF_AW-1:0] wb_addr,
  output logic [DW-1:0]    wb_data,
  output logic [2:0]       flags_q,
  output logic             illegal_instr
);
  dec_t d;
  logic accept, issue, ex_valid, wb_valid;
  logic [RF_AW-1:0] ex_rd;
  logic [DW-1:0] fwd_a, fwd_b, op_b;
  instr_field_decode u_dec (.instr(instr), .dec(d));
  assign instr_ready = ~stall_i;
  assign accept = instr_valid & ~stall_i;
  assign issue = accept & d.legal;
  assign rf_raddr_a = d.rs;
  assign rf_raddr_b = d.rt;
  // r0 reads as zero; the younger (EX) producer wins over WB, then the register file
  assign fwd_a = (d.rs == '0) ? '0 : (ex_valid && ex_rd == d.rs) ? alu_out :
                 (wb_valid && wb_addr == d.rs) ? wb_data : rf_rdata_a;
  assign fwd_b = (d.rt == '0) ? '0 : (ex_valid && ex_rd == d.rt) ? alu_out :
                 (wb_valid && wb_addr == d.rt) ? wb_data : rf_rdata_b;
  assign op_b = d.uses_rt ? fwd_b : (d.opcode == OP_ADDUI) ? {16'b0, d.imm} : '0;
  assign wb_en = wb_valid & ~stall_i & (wb_addr != '0);
  // ID/EX register: loads the decoded op, or a zeroed bubble when nothing legal is accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid <= 1'b0;
      ex_rd <= '0;
      alu_opcode <= '0;
      alu_in_a <= '0;
      alu_in_b <= '0;
    end else if (!stall_i) begin
      ex_valid <= issue;
      ex_rd <= issue ? d.rd : '0;
      alu_opcode <= issue ? d.opcode : '0;
      alu_in_a <= issue ? fwd_a : '0;
      alu_in_b <= issue ? op_b : '0;
    end
  end
  // one-cycle pulse for an accepted word with an unsupported opcode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) illegal_instr <= 1'b0;
    else illegal_instr <= accept & ~d.legal;
  end
  // EX/WB register and architectural flags: only a valid op retiring updates them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid <= 1'b0;
      wb_addr <= '0;
      wb_data <= '0;
      flags_q <= '0;
    end else if (!stall_i) begin
      wb_valid <= ex_valid;
      if (ex_valid) begin
        wb_addr <= ex_rd;
        wb_data <= alu_out;
        flags_q <= alu_flags;
      end
    end
  end
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: directed vectors with alu and register-file models around the issue stage
module tb_alu_issue_stage;
  import alu_issue_stage_pkg::*;
  logic clk, rst_n, instr_valid, instr_ready, stall_i, wb_en, illegal_instr;
  logic [31:0] instr, rf_rdata_a, rf_rdata_b, alu_in_a, alu_in_b, alu_out, wb_data;
  logic [4:0] rf_raddr_a, rf_raddr_b, wb_addr;
  logic [5:0] alu_opcode;
  logic [2:0] alu_flags, flags_q;
  logic [31:0] rf [32];
  int checks = 0;
  int errors = 0;
  alu_issue_stage dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .stall_i(stall_i), .rf_raddr_a(rf_raddr_a),
    .rf_raddr_b(rf_raddr_b), .rf_rdata_a(rf_rdata_a), .rf_rdata_b(rf_rdata_b),
    .alu_opcode(alu_opcode), .alu_in_a(alu_in_a), .alu_in_b(alu_in_b),
    .alu_out(alu_out), .alu_flags(alu_flags), .wb_en(wb_en), .wb_addr(wb_addr),
    .wb_data(wb_data), .flags_q(flags_q), .illegal_instr(illegal_instr)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  assign rf_rdata_a = (rf_raddr_a == 5'd0) ? 32'd0 : rf[rf_raddr_a];
  assign rf_rdata_b = (rf_raddr_b == 5'd0) ? 32'd0 : rf[rf_raddr_b];
  always @(posedge clk) begin
    if (!rst_n) for (int k = 0; k < 32; k++) rf[k] <= 32'd0;
    else if (wb_en) rf[wb_addr] <= wb_data;
  end
  always_comb begin
    alu_out = 32'd0;
    case (alu_opcode)
      OP_ADDU, OP_ADDUI: alu_out = alu_in_a + alu_in_b;
      OP_AND: alu_out = alu_in_a & alu_in_b;
      OP_OR:  alu_out = alu_in_a | alu_in_b;
      OP_NOT: alu_out = ~alu_in_a;
      OP_XOR: alu_out = alu_in_a ^ alu_in_b;
      OP_SL:  alu_out = alu_in_a << alu_in_b[4:0];
      OP_SR:  alu_out = alu_in_a >> alu_in_b[4:0];
      OP_SRA: alu_out = $signed(alu_in_a) >>> alu_in_b[4:0];
      default: alu_out = 32'd0;
    endcase
    alu_flags[0] = (alu_opcode == OP_ADDU || alu_opcode == OP_ADDUI) &&
                   (alu_in_a[31] == alu_in_b[31]) && (alu_out[31] != alu_in_a[31]);
    alu_flags[1] = (alu_out == 32'd0);
    alu_flags[2] = alu_out[31];
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] rr(input logic [5:0] op, input logic [4:0] rd, rs, rt);
    return {op, rd, rs, rt, 11'd0};
  endfunction
  function automatic logic [31:0] ri(input logic [5:0] op, input logic [4:0] rd, rs, input logic [15:0] imm);
    return {op, rd, rs, imm};
  endfunction
  task automatic cyc(input logic v, input logic [31:0] w);
    instr_valid = v;
    instr = w;
    @(posedge clk);
    @(negedge clk);
  endtask
  initial begin
    rst_n = 1'b0;
    stall_i = 1'b0;
    instr_valid = 1'b0;
    instr = 32'd0;
    repeat (2) @(negedge clk);
    check("rst_opcode", alu_opcode, 0);
    check("rst_in_a", alu_in_a, 0);
    check("rst_in_b", alu_in_b, 0);
    check("rst_wb_en", wb_en, 0);
    check("rst_wb_data", wb_data, 0);
    check("rst_flags", flags_q, 0);
    check("rst_illegal", illegal_instr, 0);
    check("rst_ready", instr_ready, 1);
    rst_n = 1'b1;
    @(negedge clk);
    cyc(1, ri(OP_ADDUI, 1, 0, 16'h0005));
    check("addui_op", alu_opcode, 32'(OP_ADDUI));
    check("addui_a", alu_in_a, 0);
    check("addui_b", alu_in_b, 5);
    cyc(1, rr(OP_ADDU, 2, 1, 1));
    check("r1_wb_en", wb_en, 1);
    check("r1_wb_addr", wb_addr, 1);
    check("r1_wb_data", wb_data, 5);
    check("exfwd_a", alu_in_a, 5);
    check("exfwd_b", alu_in_b, 5);
    cyc(0, 0);
    check("r2_wb_addr", wb_addr, 2);
    check("r2_wb_data", wb_data, 10);
    check("bubble_op", alu_opcode, 0);
    cyc(0, 0);
    check("bubble_wb_en", wb_en, 0);
    cyc(1, ri(OP_ADDUI, 3, 0, 16'hFFFF));
    check("r3_in_b", alu_in_b, 32'h0000FFFF);
    cyc(0, 0);
    check("r3_wb_data", wb_data, 32'h0000FFFF);
    cyc(1, rr(OP_XOR, 4, 3, 3));
    check("wbfwd_a", alu_in_a, 32'h0000FFFF);
    check("wbfwd_b", alu_in_b, 32'h0000FFFF);
    cyc(0, 0);
    check("r4_wb_addr", wb_addr, 4);
    check("r4_wb_data", wb_data, 0);
    check("r4_flags", flags_q, 3'b010);
    cyc(1, {6'h3F, 5'd5, 5'd1, 5'd1, 11'd0});
    check("ill_pulse", illegal_instr, 1);
    check("ill_bubble", alu_opcode, 0);
    cyc(0, 0);
    check("ill_pulse_end", illegal_instr, 0);
    check("ill_wb_en", wb_en, 0);
    check("ill_flags", flags_q, 3'b010);
    cyc(1, rr(OP_ADDU, 12, 1, 1));
    check("stall_op_a", alu_in_a, 5);
    stall_i = 1'b1;
    instr_valid = 1'b1;
    instr = ri(OP_ADDUI, 20, 0, 16'h0001);
    #1;
    check("stall_ready", instr_ready, 0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      @(negedge clk);
      check("stall_op_held", alu_opcode, 32'(OP_ADDU));
      check("stall_a_held", alu_in_a, 5);
      check("stall_wb_en", wb_en, 0);
    end
    stall_i = 1'b0;
    cyc(0, 0);
    check("unstall_wb_en", wb_en, 1);
    check("unstall_wb_addr", wb_addr, 12);
    check("unstall_wb_data", wb_data, 10);
    check("unstall_no_accept", alu_opcode, 0);
    cyc(0, 0);
    check("unstall_once", wb_en, 0);
    cyc(1, ri(OP_ADDUI, 0, 0, 16'h0007));
    cyc(1, rr(OP_ADDU, 13, 0, 0));
    check("r0_wb_en", wb_en, 0);
    check("r0_wb_data", wb_data, 7);
    check("r0_src_a", alu_in_a, 0);
    check("r0_src_b", alu_in_b, 0);
    cyc(0, 0);
    check("r13_wb_data", wb_data, 0);
    check("r13_flags", flags_q, 3'b010);
    cyc(1, ri(OP_ADDUI, 5, 0, 16'h8000));
    cyc(1, ri(OP_ADDUI, 6, 0, 16'd16));
    cyc(1, rr(OP_SL, 5, 5, 6));
    check("sl16_a", alu_in_a, 32'h00008000);
    check("sl16_b", alu_in_b, 16);
    cyc(1, ri(OP_ADDUI, 7, 0, 16'd4));
    check("sl16_wb", wb_data, 32'h80000000);
    cyc(1, rr(OP_SRA, 8, 5, 7));
    check("sra_a", alu_in_a, 32'h80000000);
    check("sra_b", alu_in_b, 4);
    cyc(1, ri(OP_ADDUI, 9, 0, 16'd33));
    check("sra_wb_addr", wb_addr, 8);
    check("sra_wb_data", wb_data, 32'hF8000000);
    check("sra_flags", flags_q, 3'b100);
    cyc(1, ri(OP_ADDUI, 10, 0, 16'd3));
    cyc(1, rr(OP_SL, 11, 10, 9));
    check("sl33_a", alu_in_a, 3);
    check("sl33_b", alu_in_b, 33);
    cyc(0, 0);
    check("sl33_wb_addr", wb_addr, 11);
    check("sl33_wb_data", wb_data, 6);
    cyc(1, rr(OP_SRA, 14, 5, 7));
    cyc(1, ri(OP_ADDUI, 15, 0, 16'd9));
    check("pre_rst_flags", flags_q, 3'b100);
    #2 rst_n = 1'b0;
    #1;
    check("arst_opcode", alu_opcode, 0);
    check("arst_wb_en", wb_en, 0);
    check("arst_wb_addr", wb_addr, 0);
    check("arst_wb_data", wb_data, 0);
    check("arst_flags", flags_q, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1, ri(OP_ADDUI, 15, 0, 16'd2));
    check("post_rst_b", alu_in_b, 2);
    cyc(0, 0);
    check("post_rst_wb_en", wb_en, 1);
    check("post_rst_wb_addr", wb_addr, 15);
    check("post_rst_wb_data", wb_data, 2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
